// File: rtl/ddr5_bank_sched.sv
// ddr5_bank_sched
// In-order DDR5 command scheduler. CPU requests are buffered in a FIFO. The
// head request is sequenced as ACT -> RD/WR -> PRE on the DIMM command bus,
// with at most one command per cycle. Per-bank counters enforce tRCD, tRAS,
// tRP and the pre-charge gate (tRTP, or write recovery). Shared counters
// enforce tRRD_L/tRRD_S. A small in-order completion FIFO times each data
// burst and pulses done_valid when the burst ends.
//
// Optional build macro OPEN_PAGE_EN: keeps a per-bank open-row table. A row
// hit skips ACT, a row miss precharges first, and a CAS pops the request
// without closing the row. When the macro is undefined every request runs
// closed-page: ACT -> CAS -> PRE.
//
// Ports:
//   clock, reset_n                        clock, asynchronous active-low reset
//   req_valid/req_ready                   request handshake
//   req_write/bg/ba/row/col               request fields
//   cmd_valid, cmd_type                   issued command (0 NOP 1 ACT 2 RD 3 WR 4 PRE)
//   cmd_bg/ba/row/col                     command address (0 when no command)
//   done_valid, done_write                data burst completion pulse and its type
//   q_count                               occupied request queue entries
module ddr5_bank_sched #(
    parameter int DEPTH        = 16,
    parameter int NUM_BG       = 8,
    parameter int BANKS_PER_BG = 4,
    parameter int ROW_W        = 16,
    parameter int COL_W        = 10,
    parameter int CNT_W        = 8,
    parameter int T_RCD        = 39,
    parameter int T_RP         = 39,
    parameter int T_RAS        = 76,
    parameter int T_RTP        = 18,
    parameter int T_WR         = 72,
    parameter int T_CL         = 40,
    parameter int T_CWD        = 38,
    parameter int T_BURST      = 8,
    parameter int T_RRD_L      = 12,
    parameter int T_RRD_S      = 8
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [$clog2(NUM_BG)-1:0]       req_bg,
    input  logic [$clog2(BANKS_PER_BG)-1:0] req_ba,
    input  logic [ROW_W-1:0]                req_row,
    input  logic [COL_W-1:0]                req_col,
    output logic                            cmd_valid,
    output logic [2:0]                      cmd_type,
    output logic [$clog2(NUM_BG)-1:0]       cmd_bg,
    output logic [$clog2(BANKS_PER_BG)-1:0] cmd_ba,
    output logic [ROW_W-1:0]                cmd_row,
    output logic [COL_W-1:0]                cmd_col,
    output logic                            done_valid,
    output logic                            done_write,
    output logic [$clog2(DEPTH+1)-1:0]      q_count
);
    localparam int BG_W     = $clog2(NUM_BG);
    localparam int BA_W     = $clog2(BANKS_PER_BG);
    localparam int NB       = NUM_BG * BANKS_PER_BG;
    localparam int BK_W     = $clog2(NB);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int QC_W     = $clog2(DEPTH + 1);
    localparam int CF_DEPTH = 4;
    localparam int CMAX     = (1 << CNT_W) - 1;

    localparam bit PARAM_OK = (T_RCD <= CMAX) && (T_RP <= CMAX) && (T_RAS <= CMAX) &&
                              (T_RTP <= CMAX) && (T_RRD_L <= CMAX) && (T_RRD_S <= CMAX) &&
                              (T_CWD + T_BURST + T_WR <= CMAX) && (T_CL + T_BURST <= CMAX) &&
                              (T_RCD >= 1) && (T_RP >= 1) && (T_RAS >= 1) && (T_RTP >= 1) &&
                              (T_RRD_L >= 1) && (T_RRD_S >= 1) && (T_CWD + T_BURST >= 1);
    generate
        if (!PARAM_OK) begin : g_param_check
            $error("ddr5_bank_sched: timing parameter does not fit CNT_W");
        end
    endgenerate

    // Counters hold tX-1 after issue so the dependent command may go on the
    // cycle the counter reads 0, i.e. exactly tX cycles after issue.
    localparam logic [CNT_W-1:0] L_RCD     = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] L_RP      = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] L_RAS     = CNT_W'(T_RAS - 1);
    localparam logic [CNT_W-1:0] L_RTP     = CNT_W'(T_RTP - 1);
    localparam logic [CNT_W-1:0] L_WRGATE  = CNT_W'(T_CWD + T_BURST + T_WR - 1);
    localparam logic [CNT_W-1:0] L_RDDATA  = CNT_W'(T_CL + T_BURST - 1);
    localparam logic [CNT_W-1:0] L_WRDATA  = CNT_W'(T_CWD + T_BURST - 1);
    localparam logic [CNT_W-1:0] L_RRD_L   = CNT_W'(T_RRD_L - 1);
    localparam logic [CNT_W-1:0] L_RRD_S   = CNT_W'(T_RRD_S - 1);

`ifdef OPEN_PAGE_EN
    localparam bit OPEN_PAGE = 1'b1;
`else
    localparam bit OPEN_PAGE = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ACT, S_CAS, S_PRE} state_t;
    state_t state_q, state_d;

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    // Request queue storage (not reset; only the pointers are)
    logic             q_write_mem [DEPTH];
    logic [BG_W-1:0]  q_bg_mem    [DEPTH];
    logic [BA_W-1:0]  q_ba_mem    [DEPTH];
    logic [ROW_W-1:0] q_row_mem   [DEPTH];
    logic [COL_W-1:0] q_col_mem   [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [QC_W-1:0]  q_count_q, q_count_d;

    logic [CNT_W-1:0] trcd_q [NB], trcd_d [NB];
    logic [CNT_W-1:0] tras_q [NB], tras_d [NB];
    logic [CNT_W-1:0] trp_q  [NB], trp_d  [NB];
    logic [CNT_W-1:0] pg_q   [NB], pg_d   [NB];
    logic [CNT_W-1:0] trrd_l_q, trrd_l_d, trrd_s_q, trrd_s_d;
    logic [BG_W-1:0]  last_bg_q, last_bg_d;

    logic             cf_wr_q  [CF_DEPTH], cf_wr_d  [CF_DEPTH];
    logic [CNT_W-1:0] cf_tmr_q [CF_DEPTH], cf_tmr_d [CF_DEPTH];
    logic [1:0]       cf_head_q, cf_head_d, cf_tail;
    logic [2:0]       cf_cnt_q, cf_cnt_d;

    logic             head_write;
    logic [BG_W-1:0]  head_bg;
    logic [BA_W-1:0]  head_ba;
    logic [ROW_W-1:0] head_row;
    logic [COL_W-1:0] head_col;
    logic [BK_W-1:0]  head_bank;
    logic             act_ok, cas_ok, pre_ok, row_open, row_hit;
    logic             do_act, do_cas, do_pre, do_pop, push;
    state_t           state_after_pop;

    assign head_write = q_write_mem[head_q];
    assign head_bg    = q_bg_mem[head_q];
    assign head_ba    = q_ba_mem[head_q];
    assign head_row   = q_row_mem[head_q];
    assign head_col   = q_col_mem[head_q];
    assign head_bank  = BK_W'(head_bg) * BK_W'(BANKS_PER_BG) + BK_W'(head_ba);

    // tRRD_L applies within the bank group of the previous ACT, tRRD_S across groups
    assign act_ok = (trp_q[head_bank] == '0) &&
                    ((head_bg == last_bg_q) ? (trrd_l_q == '0) : (trrd_s_q == '0));
    assign cas_ok = (trcd_q[head_bank] == '0) && (cf_cnt_q != 3'(CF_DEPTH));
    assign pre_ok = (tras_q[head_bank] == '0) && (pg_q[head_bank] == '0);
    assign state_after_pop = (q_count_q > QC_W'(1)) ? S_ACT : S_IDLE;

`ifdef OPEN_PAGE_EN
    logic             open_v_q   [NB], open_v_d   [NB];
    logic [ROW_W-1:0] open_row_q [NB], open_row_d [NB];
    assign row_open = open_v_q[head_bank];
    assign row_hit  = open_v_q[head_bank] && (open_row_q[head_bank] == head_row);
`else
    assign row_open = 1'b0;
    assign row_hit  = 1'b0;
`endif

    // Head FSM. IDLE with a non-empty queue behaves like ACT so a request can
    // issue its ACT the cycle after it is accepted.
    always_comb begin
        state_d = state_q;
        do_act  = 1'b0;
        do_cas  = 1'b0;
        do_pre  = 1'b0;
        do_pop  = 1'b0;
        case (state_q)
            S_IDLE, S_ACT: begin
                if (q_count_q == '0) begin
                    state_d = S_IDLE;
                end else if (row_hit) begin
                    state_d = S_ACT;
                    if (cas_ok) begin
                        do_cas  = 1'b1;
                        do_pop  = 1'b1;
                        state_d = state_after_pop;
                    end
                end else if (row_open) begin
                    // wrong row open: close it, then ACT once tRP expires
                    state_d = S_ACT;
                    do_pre  = pre_ok;
                end else if (act_ok) begin
                    do_act  = 1'b1;
                    state_d = S_CAS;
                end else begin
                    state_d = S_ACT;
                end
            end
            S_CAS: begin
                if (cas_ok) begin
                    do_cas = 1'b1;
                    if (OPEN_PAGE) begin
                        do_pop  = 1'b1;
                        state_d = state_after_pop;
                    end else begin
                        state_d = S_PRE;
                    end
                end
            end
            S_PRE: begin
                if (pre_ok) begin
                    do_pre  = 1'b1;
                    do_pop  = 1'b1;
                    state_d = state_after_pop;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_valid = do_act | do_cas | do_pre;
    assign cmd_type  = do_act ? 3'd1 : do_cas ? (head_write ? 3'd3 : 3'd2) : do_pre ? 3'd4 : 3'd0;
    assign cmd_bg    = cmd_valid ? head_bg  : '0;
    assign cmd_ba    = cmd_valid ? head_ba  : '0;
    assign cmd_row   = cmd_valid ? head_row : '0;
    assign cmd_col   = cmd_valid ? head_col : '0;

    // A slot freed by this cycle's pop can be refilled in the same cycle
    assign req_ready = (q_count_q != QC_W'(DEPTH)) || do_pop;
    assign push      = req_valid && req_ready;
    assign q_count   = q_count_q;

    always_comb begin
        head_d    = do_pop ? ((head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + 1'b1) : head_q;
        tail_d    = push ? ((tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + 1'b1) : tail_q;
        q_count_d = q_count_q + QC_W'(push) - QC_W'(do_pop);
    end

    // Timing counters
    always_comb begin
        trrd_l_d  = do_act ? L_RRD_L : dec_sat(trrd_l_q);
        trrd_s_d  = do_act ? L_RRD_S : dec_sat(trrd_s_q);
        last_bg_d = do_act ? head_bg : last_bg_q;
        for (int i = 0; i < NB; i++) begin
            trcd_d[i] = dec_sat(trcd_q[i]);
            tras_d[i] = dec_sat(tras_q[i]);
            trp_d[i]  = dec_sat(trp_q[i]);
            pg_d[i]   = dec_sat(pg_q[i]);
`ifdef OPEN_PAGE_EN
            open_v_d[i]   = open_v_q[i];
            open_row_d[i] = open_row_q[i];
`endif
            if (BK_W'(i) == head_bank) begin
                if (do_act) begin
                    trcd_d[i] = L_RCD;
                    tras_d[i] = L_RAS;
`ifdef OPEN_PAGE_EN
                    open_v_d[i]   = 1'b1;
                    open_row_d[i] = head_row;
`endif
                end
                if (do_cas) pg_d[i] = head_write ? L_WRGATE : L_RTP;
                if (do_pre) begin
                    trp_d[i] = L_RP;
`ifdef OPEN_PAGE_EN
                    open_v_d[i] = 1'b0;
`endif
                end
            end
        end
    end

    // Completion FIFO: one data timer per outstanding CAS, retired strictly in order
    assign cf_tail    = cf_head_q + cf_cnt_q[1:0];
    assign done_valid = (cf_cnt_q != '0) && (cf_tmr_q[cf_head_q] == '0);
    assign done_write = done_valid && cf_wr_q[cf_head_q];

    always_comb begin
        cf_head_d = cf_head_q + 2'(done_valid);
        cf_cnt_d  = cf_cnt_q + 3'(do_cas) - 3'(done_valid);
        for (int j = 0; j < CF_DEPTH; j++) begin
            cf_tmr_d[j] = dec_sat(cf_tmr_q[j]);
            cf_wr_d[j]  = cf_wr_q[j];
            if (do_cas && (cf_tail == 2'(j))) begin
                cf_tmr_d[j] = head_write ? L_WRDATA : L_RDDATA;
                cf_wr_d[j]  = head_write;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            q_write_mem[tail_q] <= req_write;
            q_bg_mem[tail_q]    <= req_bg;
            q_ba_mem[tail_q]    <= req_ba;
            q_row_mem[tail_q]   <= req_row;
            q_col_mem[tail_q]   <= req_col;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            q_count_q <= '0;
            trrd_l_q  <= '0;
            trrd_s_q  <= '0;
            last_bg_q <= '0;
            cf_head_q <= '0;
            cf_cnt_q  <= '0;
            for (int i = 0; i < NB; i++) begin
                trcd_q[i] <= '0;
                tras_q[i] <= '0;
                trp_q[i]  <= '0;
                pg_q[i]   <= '0;
`ifdef OPEN_PAGE_EN
                open_v_q[i]   <= 1'b0;
                open_row_q[i] <= '0;
`endif
            end
            for (int j = 0; j < CF_DEPTH; j++) begin
                cf_tmr_q[j] <= '0;
                cf_wr_q[j]  <= 1'b0;
            end
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            q_count_q <= q_count_d;
            trrd_l_q  <= trrd_l_d;
            trrd_s_q  <= trrd_s_d;
            last_bg_q <= last_bg_d;
            cf_head_q <= cf_head_d;
            cf_cnt_q  <= cf_cnt_d;
            for (int i = 0; i < NB; i++) begin
                trcd_q[i] <= trcd_d[i];
                tras_q[i] <= tras_d[i];
                trp_q[i]  <= trp_d[i];
                pg_q[i]   <= pg_d[i];
`ifdef OPEN_PAGE_EN
                open_v_q[i]   <= open_v_d[i];
                open_row_q[i] <= open_row_d[i];
`endif
            end
            for (int j = 0; j < CF_DEPTH; j++) begin
                cf_tmr_q[j] <= cf_tmr_d[j];
                cf_wr_q[j]  <= cf_wr_d[j];
            end
        end
    end
endmodule

// File: tb/tb_ddr5_bank_sched.sv
// Directed testbench for ddr5_bank_sched (default parameters). Cycle numbers
// are relative to the cycle in which the first request of a test is offered.
module tb_ddr5_bank_sched;
    localparam int BG_W  = 3;
    localparam int BA_W  = 2;
    localparam int ROW_W = 16;
    localparam int COL_W = 10;
    localparam int QC_W  = 5;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_write = 1'b0;
    logic [BG_W-1:0]  req_bg = '0;
    logic [BA_W-1:0]  req_ba = '0;
    logic [ROW_W-1:0] req_row = '0;
    logic [COL_W-1:0] req_col = '0;
    logic             cmd_valid;
    logic [2:0]       cmd_type;
    logic [BG_W-1:0]  cmd_bg;
    logic [BA_W-1:0]  cmd_ba;
    logic [ROW_W-1:0] cmd_row;
    logic [COL_W-1:0] cmd_col;
    logic             done_valid;
    logic             done_write;
    logic [QC_W-1:0]  q_count;

    ddr5_bank_sched dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_bg     (req_bg),
        .req_ba     (req_ba),
        .req_row    (req_row),
        .req_col    (req_col),
        .cmd_valid  (cmd_valid),
        .cmd_type   (cmd_type),
        .cmd_bg     (cmd_bg),
        .cmd_ba     (cmd_ba),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .done_valid (done_valid),
        .done_write (done_write),
        .q_count    (q_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    int base = 0;
    int checks = 0;
    int failures = 0;
    bit log_en = 1'b0;
    int cmd_rel[$];
    int cmd_typ[$];
    int cmd_bank[$];
    int cmd_rowq[$];
    int done_rel[$];
    int done_wr[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Records every command and completion the DUT produces
    always @(negedge clock) begin
        if (log_en) begin
            if (cmd_valid) begin
                cmd_rel.push_back(cyc - base);
                cmd_typ.push_back(int'(cmd_type));
                cmd_bank.push_back(int'(cmd_ba));
                cmd_rowq.push_back(int'(cmd_row));
                $display("  cmd  t=%0d type=%0d bg=%0d ba=%0d row=%0d", cyc - base, cmd_type, cmd_bg, cmd_ba, cmd_row);
            end
            if (done_valid) begin
                done_rel.push_back(cyc - base);
                done_wr.push_back(int'(done_write));
                $display("  done t=%0d write=%0d", cyc - base, done_write);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        cmd_rel.delete(); cmd_typ.delete(); cmd_bank.delete(); cmd_rowq.delete();
        done_rel.delete(); done_wr.delete();
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic run_to(input int rel);
        while (cyc - base < rel) @(negedge clock);
    endtask

    task automatic do_reset();
        log_en = 1'b0;
        reset_n = 1'b0;
        req_valid = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        clear_logs();
        log_en = 1'b1;
    endtask

    task automatic drive(input logic wr, input int bg, input int ba, input int row, input int col);
        req_valid = 1'b1;
        req_write = wr;
        req_bg    = BG_W'(bg);
        req_ba    = BA_W'(ba);
        req_row   = ROW_W'(row);
        req_col   = COL_W'(col);
    endtask

    task automatic chk_cmd(input string tag, input int idx, input int rel, input int typ);
        int orel;
        int otyp;
        orel = (idx < cmd_rel.size()) ? cmd_rel[idx] : -1;
        otyp = (idx < cmd_typ.size()) ? cmd_typ[idx] : -1;
        chk({tag, "_cycle"}, orel, rel);
        chk({tag, "_type"}, otyp, typ);
    endtask

    task automatic chk_done(input string tag, input int idx, input int rel, input int wr);
        int orel;
        int owr;
        orel = (idx < done_rel.size()) ? done_rel[idx] : -1;
        owr  = (idx < done_wr.size()) ? done_wr[idx] : -1;
        chk({tag, "_cycle"}, orel, rel);
        chk({tag, "_write"}, owr, wr);
    endtask

    initial begin
        int acc;

        // ---- reset state, observed while reset is held ----
        reset_n = 1'b0;
        repeat (2) step();
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_type", cmd_type, 0);
        chk("rst_cmd_addr", {cmd_bg, cmd_ba, cmd_row, cmd_col}, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_q_count", q_count, 0);
        chk("rst_req_ready", req_ready, 1);

        // ---- single read bg0/ba0/row5 ----
        do_reset();
        $display("test single_read");
        base = cyc;
        drive(1'b0, 0, 0, 5, 3);
        step();
        req_valid = 1'b0;
        chk("rd_q_count_1", q_count, 1);
        run_to(77);
        chk("rd_q_count_77", q_count, 1);
        step();
        chk("rd_q_count_78", q_count, 0);
        run_to(100);
        chk("rd_ncmd", cmd_rel.size(), 3);
        chk_cmd("rd_act", 0, 1, 1);
        chk("rd_act_row", (cmd_rowq.size() > 0) ? cmd_rowq[0] : -1, 5);
        chk_cmd("rd_rd", 1, 40, 2);
        chk_cmd("rd_pre", 2, 77, 4);
        chk("rd_ndone", done_rel.size(), 1);
        chk_done("rd_done", 0, 88, 0);

        // ---- single write, same address ----
        do_reset();
        $display("test single_write");
        base = cyc;
        drive(1'b1, 0, 0, 5, 3);
        step();
        req_valid = 1'b0;
        run_to(170);
        chk("wr_ncmd", cmd_rel.size(), 3);
        chk_cmd("wr_act", 0, 1, 1);
        chk_cmd("wr_wr", 1, 40, 3);
        chk_cmd("wr_pre", 2, 158, 4);
        chk_done("wr_done", 0, 86, 1);

        // ---- two reads, different banks in bg0 ----
        do_reset();
        $display("test two_reads_diff_bank");
        base = cyc;
        drive(1'b0, 0, 0, 5, 0);
        step();
        drive(1'b0, 0, 1, 7, 0);
        step();
        req_valid = 1'b0;
        run_to(180);
        chk("db_ncmd", cmd_rel.size(), 6);
        chk_cmd("db_pre0", 2, 77, 4);
        chk_cmd("db_act1", 3, 78, 1);
        chk("db_act1_ba", (cmd_bank.size() > 3) ? cmd_bank[3] : -1, 1);
        chk_cmd("db_rd1", 4, 117, 2);
        chk_cmd("db_pre1", 5, 154, 4);
        chk_done("db_done0", 0, 88, 0);
        chk_done("db_done1", 1, 165, 0);

        // ---- two reads, same bank ----
        do_reset();
        $display("test two_reads_same_bank");
        base = cyc;
        drive(1'b0, 0, 0, 5, 0);
        step();
        drive(1'b0, 0, 0, 9, 0);
        step();
        req_valid = 1'b0;
        run_to(130);
        chk_cmd("sb_act1", 3, 116, 1);

        // ---- fill the queue: 17 back-to-back offers ----
        do_reset();
        $display("test fill");
        base = cyc;
        acc = 0;
        for (int r = 0; r <= 77; r++) begin
            run_to(r);
            drive(1'b0, acc % 8, (acc / 8) % 4, acc, 0);
            if (r == 15) chk("fill_ready_15", req_ready, 1);
            if (r == 16) begin
                chk("fill_ready_16", req_ready, 0);
                chk("fill_count_16", q_count, 16);
                chk("fill_acc_16", acc, 16);
            end
            if (r == 76) chk("fill_ready_76", req_ready, 0);
            if (r == 77) begin
                chk("fill_ready_77", req_ready, 1);
                chk("fill_count_77", q_count, 16);
            end
            if (req_ready) acc++;
        end
        step();
        req_valid = 1'b0;
        chk("fill_count_78", q_count, 16);
        chk("fill_accepted", acc, 17);

        // ---- reset in the middle of a read ----
        do_reset();
        $display("test reset_mid_read");
        base = cyc;
        drive(1'b0, 0, 0, 5, 0);
        step();
        req_valid = 1'b0;
        run_to(50);
        reset_n = 1'b0;
        #1;
        chk("mr_cmd_valid", cmd_valid, 0);
        chk("mr_done_valid", done_valid, 0);
        chk("mr_q_count", q_count, 0);
        chk("mr_req_ready", req_ready, 1);
        clear_logs();
        repeat (2) step();
        reset_n = 1'b1;
        run_to(200);
        chk("mr_no_done", done_rel.size(), 0);
        chk("mr_no_cmd", cmd_rel.size(), 0);

`ifdef OPEN_PAGE_EN
        // ---- open page: hit, hit, miss ----
        do_reset();
        $display("test open_page");
        base = cyc;
        drive(1'b0, 0, 0, 5, 0);
        step();
        drive(1'b0, 0, 0, 5, 1);
        step();
        drive(1'b0, 0, 0, 6, 2);
        step();
        req_valid = 1'b0;
        run_to(220);
        chk("op_ncmd", cmd_rel.size(), 6);
        chk_cmd("op_act0", 0, 1, 1);
        chk_cmd("op_rd0", 1, 40, 2);
        chk_cmd("op_rd1", 2, 41, 2);
        chk_cmd("op_pre", 3, 77, 4);
        chk_cmd("op_act2", 4, 116, 1);
        chk_cmd("op_rd2", 5, 155, 2);
        chk_done("op_done2", 2, 203, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
